// File: rtl/ufi_pkg.sv
// Shared UFI bus constants and the write arbiter state encoding.
package ufi_pkg;

    localparam int UFI_BUS_W         = 32;
    localparam int USI_BUS_W         = 32;
    localparam int UFI_SLAVE_SEL_MSB = 31;
    localparam int UFI_SLAVE_SEL_LSB = 28;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } arb_state_t;

endpackage

// File: rtl/ufi_rr_picker.sv
// Combinational round-robin priority encoder: first requester after the last winner.
module ufi_rr_picker #(
    parameter int pMasterNum = 4
) (
    input  logic [pMasterNum-1:0]         req,
    input  logic [$clog2(pMasterNum)-1:0] last,
    output logic [$clog2(pMasterNum)-1:0] winner,
    output logic                          valid
);

    localparam int          IW = $clog2(pMasterNum);
    localparam int unsigned N  = pMasterNum;

    logic [IW-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = IW'((32'(last) + i) % N);
            if (!valid && req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ufi_write_arbiter.sv
// Round-robin arbiter sharing one UFI slave write bus among several masters,
// with a registered output path, a burst fairness limit and per-master lock.
module ufi_write_arbiter
    import ufi_pkg::*;
#(
    parameter int pUfiBusWidth = UFI_BUS_W,
    parameter int pUsiBusWidth = USI_BUS_W,
    parameter int pMasterNum   = 4,
    parameter int pBurstMax    = 16
) (
    input  logic                               iCLK,
    input  logic                               iRST,
    input  logic [pMasterNum*pUfiBusWidth-1:0] iMUfiWd,
    input  logic [pMasterNum*pUsiBusWidth-1:0] iMUfiWAdrs,
    input  logic [pMasterNum-1:0]              iMUfiWEd,
    input  logic [pMasterNum-1:0]              iMUfiLock,
    output logic [pMasterNum-1:0]              oMUfiRdy,
    output logic [pUfiBusWidth-1:0]            oSUfiWd,
    output logic [pUsiBusWidth-1:0]            oSUfiWAdrs,
    output logic                               oSUfiWEd,
    output logic [pMasterNum-1:0]              oGrant,
    output logic                               oBusy
);

    localparam int            IW        = $clog2(pMasterNum);
    localparam int            CW        = $clog2(pBurstMax + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(pBurstMax);

    arb_state_t              state, state_next;
    logic [IW-1:0]           owner, owner_next, last, last_next, pick;
    logic                    pick_valid;
    logic [CW-1:0]           count, count_next, count_inc;
    logic [pMasterNum-1:0]   owner_oh, others_req, rdy_next;
    logic                    beat, hit, release_now, busy_next;
    logic [pUfiBusWidth-1:0] wd_arr   [pMasterNum];
    logic [pUsiBusWidth-1:0] adrs_arr [pMasterNum];

    always_comb begin
        for (int unsigned m = 0; m < pMasterNum; m++) begin
            wd_arr[m]   = iMUfiWd[m*pUfiBusWidth +: pUfiBusWidth];
            adrs_arr[m] = iMUfiWAdrs[m*pUsiBusWidth +: pUsiBusWidth];
        end
    end

    ufi_rr_picker #(
        .pMasterNum(pMasterNum)
    ) u_picker (
        .req   (iMUfiWEd),
        .last  (last),
        .winner(pick),
        .valid (pick_valid)
    );

    assign owner_oh    = pMasterNum'(1) << owner;
    assign others_req  = iMUfiWEd & ~owner_oh;
    assign beat        = (state == ST_GRANT) && iMUfiWEd[owner] && oMUfiRdy[owner];
    assign count_inc   = (count == BURST_MAX) ? count : count + 1'b1;
    assign hit         = beat && (count_inc == BURST_MAX);
    assign release_now = (state == ST_GRANT) && !iMUfiLock[owner] &&
                         (!iMUfiWEd[owner] || (hit && |others_req));

    always_comb begin
        state_next = state;
        owner_next = owner;
        last_next  = last;
        count_next = count;
        unique case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_next = ST_GRANT;
                    owner_next = pick;
                    count_next = '0;
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    state_next = ST_IDLE;
                    last_next  = owner;
                    count_next = '0;
                end else if (beat) begin
                    // Alone at the limit: restart the window; locked with waiters: saturate.
                    count_next = (hit && !(|others_req)) ? '0 : count_inc;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        rdy_next  = (state_next == ST_GRANT) ? (pMasterNum'(1) << owner_next) : '0;
        busy_next = (state_next == ST_GRANT);
    end

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            state      <= ST_IDLE;
            owner      <= '0;
            last       <= IW'(pMasterNum - 1);
            count      <= '0;
            oMUfiRdy   <= '0;
            oGrant     <= '0;
            oBusy      <= 1'b0;
            oSUfiWEd   <= 1'b0;
            oSUfiWd    <= '0;
            oSUfiWAdrs <= '0;
        end else begin
            state    <= state_next;
            owner    <= owner_next;
            last     <= last_next;
            count    <= count_next;
            oMUfiRdy <= rdy_next;
            oGrant   <= rdy_next;
            oBusy    <= busy_next;
            oSUfiWEd <= beat;
            if (beat) begin
                oSUfiWd    <= wd_arr[owner];
                oSUfiWAdrs <= adrs_arr[owner];
            end
        end
    end

endmodule

// File: tb/tb_ufi_write_arbiter.sv
// Self-checking bench: queue-driven master agents, a behavioural arbitration
// model compared every cycle, plus directed scenarios with literal expectations.
module tb_ufi_write_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int BM = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N*W-1:0]  wd_bus = '0;
    logic [N*W-1:0]  adrs_bus = '0;
    logic [N-1:0]    wed = '0;
    logic [N-1:0]    lock = '0;
    logic [N-1:0]    oMUfiRdy, oGrant;
    logic [W-1:0]    oSUfiWd, oSUfiWAdrs;
    logic            oSUfiWEd, oBusy;

    int checks = 0;
    int errors = 0;

    ufi_write_arbiter #(
        .pUfiBusWidth(W),
        .pUsiBusWidth(W),
        .pMasterNum  (N),
        .pBurstMax   (BM)
    ) dut (
        .iCLK      (clk),
        .iRST      (rst),
        .iMUfiWd   (wd_bus),
        .iMUfiWAdrs(adrs_bus),
        .iMUfiWEd  (wed),
        .iMUfiLock (lock),
        .oMUfiRdy  (oMUfiRdy),
        .oSUfiWd   (oSUfiWd),
        .oSUfiWAdrs(oSUfiWAdrs),
        .oSUfiWEd  (oSUfiWEd),
        .oGrant    (oGrant),
        .oBusy     (oBusy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Master agents: each master offers the head of its queue until accepted.
    logic [63:0] beat_q [N][$];
    logic [N-1:0] lock_req = '0;
    logic [N-1:0] acc_q = '0;

    always @(posedge clk) acc_q <= rst ? (wed & oMUfiRdy) : '0;

    always @(negedge clk) begin
        for (int m = 0; m < N; m++) begin
            if (acc_q[m] && beat_q[m].size() > 0) void'(beat_q[m].pop_front());
            if (beat_q[m].size() > 0) begin
                wed[m] = 1'b1;
                wd_bus[m*W +: W]   = beat_q[m][0][31:0];
                adrs_bus[m*W +: W] = beat_q[m][0][63:32];
            end else begin
                wed[m] = 1'b0;
            end
            lock[m] = lock_req[m] && wed[m];
        end
    end

    // Behavioural model: owner index (-1 when idle), beats in current window.
    int           m_owner = -1;
    int           m_last = N - 1;
    int           m_beats = 0;
    logic [N-1:0] e_rdy = '0;
    logic         e_busy = 1'b0;
    logic         e_wed = 1'b0;
    logic [W-1:0] e_wd = '0;
    logic [W-1:0] e_adrs = '0;
    bit           model_ok = 1'b0;

    always @(posedge clk) begin
        int c;
        bit found;
        bit waiting;
        model_ok = 1'b1;
        if (!rst) begin
            m_owner = -1; m_last = N - 1; m_beats = 0;
            e_rdy = '0; e_busy = 1'b0; e_wed = 1'b0; e_wd = '0; e_adrs = '0;
        end else begin
            e_wed = 1'b0;
            if (m_owner < 0) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (!found && wed[c]) begin
                        found = 1'b1; m_owner = c; m_beats = 0;
                    end
                end
            end else begin
                waiting = (wed & ~(N'(1) << m_owner)) != '0;
                if (wed[m_owner]) begin
                    e_wed  = 1'b1;
                    e_wd   = wd_bus[m_owner*W +: W];
                    e_adrs = adrs_bus[m_owner*W +: W];
                    m_beats++;
                end
                if (!lock[m_owner] && (!wed[m_owner] || (m_beats >= BM && waiting))) begin
                    m_last = m_owner; m_owner = -1; m_beats = 0;
                end else if (m_beats >= BM) begin
                    m_beats = waiting ? BM : 0;
                end
            end
            e_rdy  = (m_owner < 0) ? '0 : (N'(1) << m_owner);
            e_busy = (m_owner >= 0);
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("model_rdy",   oMUfiRdy,   e_rdy);
            chk("model_grant", oGrant,     e_rdy);
            chk("model_busy",  oBusy,      e_busy);
            chk("model_wed",   oSUfiWEd,   e_wed);
            chk("model_wd",    oSUfiWd,    e_wd);
            chk("model_adrs",  oSUfiWAdrs, e_adrs);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int m, input logic [31:0] a, input logic [31:0] d);
        beat_q[m].push_back({a, d});
    endtask

    function automatic bit queues_empty();
        bit e = 1'b1;
        for (int m = 0; m < N; m++) if (beat_q[m].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic drain(input string name);
        int i = 0;
        while (!(queues_empty() && !oBusy) && i < 3000) begin
            step();
            i++;
        end
        step();
        chk({name, "_drain_timeout"}, (i < 3000) ? 1 : 0, 1);
    endtask

    initial begin
        int n0;
        int n;
        bit done;
        int len;

        // Reset state
        step(); step();
        chk("reset_rdy", oMUfiRdy, 0);
        chk("reset_wed", oSUfiWEd, 0);
        chk("reset_busy", oBusy, 0);
        chk("reset_adrs", oSUfiWAdrs, 0);
        rst = 1'b1;
        step();

        // Single master 1, three beats
        push(1, 32'h1000_0000, 32'h1000_00a0);
        push(1, 32'h1000_0004, 32'h1000_00a1);
        push(1, 32'h1000_0008, 32'h1000_00a2);
        step();
        chk("t1_rdy_rise", oMUfiRdy, 4'b0010);
        chk("t1_no_wed_yet", oSUfiWEd, 0);
        chk("t1_model_pin", e_rdy, 4'b0010);
        step();
        chk("t1_b0_wed", oSUfiWEd, 1);
        chk("t1_b0_adrs", oSUfiWAdrs, 32'h1000_0000);
        chk("t1_b0_wd", oSUfiWd, 32'h1000_00a0);
        step();
        chk("t1_b1_adrs", oSUfiWAdrs, 32'h1000_0004);
        step();
        chk("t1_b2_wed", oSUfiWEd, 1);
        chk("t1_b2_wd", oSUfiWd, 32'h1000_00a2);
        step();
        chk("t1_rdy_drop", oMUfiRdy, 0);
        chk("t1_wed_done", oSUfiWEd, 0);
        drain("t1");

        // Masters 0 and 2 together, from reset
        rst = 1'b0; step(); step(); rst = 1'b1;
        push(0, 32'h2000_0000, 32'h0000_0001);
        push(0, 32'h2000_0004, 32'h0000_0002);
        push(2, 32'h2000_0100, 32'h2000_0001);
        push(2, 32'h2000_0104, 32'h2000_0002);
        step();
        chk("t2_first_grant", oGrant, 4'b0001);
        step(); step(); step();
        chk("t2_bubble", oGrant, 4'b0000);
        step();
        chk("t2_second_grant", oGrant, 4'b0100);
        drain("t2");

        // Burst limit: master 0 streams, master 3 joins
        for (int i = 0; i < 20; i++) push(0, 32'h4000_0000 + 32'(i*4), 32'h0000_0100 + 32'(i));
        n0 = 0; done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            step();
            if (i == 2) begin
                push(3, 32'h4300_0000, 32'h3000_0000);
                push(3, 32'h4300_0004, 32'h3000_0001);
            end
            if (oSUfiWEd && oSUfiWd[31:28] == 4'h0) n0++;
            if (oGrant == 4'b1000) done = 1'b1;
        end
        chk("t3_beats_before_switch", n0, BM);
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            step();
            if (oGrant == 4'b0001) done = 1'b1;
        end
        chk("t3_m0_regain", done, 1);
        drain("t3");

        // Same with lock: master 0 keeps the bus beyond the limit
        lock_req[0] = 1'b1;
        for (int i = 0; i < 24; i++) push(0, 32'h5000_0000 + 32'(i*4), 32'h0000_0200 + 32'(i));
        n0 = 0; done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            step();
            if (i == 2) begin
                push(3, 32'h5300_0000, 32'h3000_0010);
                push(3, 32'h5300_0004, 32'h3000_0011);
            end
            if (oSUfiWEd && oSUfiWd[31:28] == 4'h0) n0++;
            if (oGrant == 4'b1000) done = 1'b1;
        end
        chk("t4_locked_beats", n0, 24);
        drain("t4");
        lock_req = '0;

        // Reset in the middle of a burst
        for (int i = 0; i < 10; i++) push(2, 32'h6000_0000 + 32'(i*4), 32'h2000_0300 + 32'(i));
        n = 0; done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            step();
            if (oSUfiWEd) n++;
            if (n == 5) done = 1'b1;
        end
        chk("t5_reached_beat5", n, 5);
        rst = 1'b0;
        step();
        chk("t5_rst_wed", oSUfiWEd, 0);
        chk("t5_rst_rdy", oMUfiRdy, 0);
        chk("t5_rst_grant", oGrant, 0);
        chk("t5_rst_busy", oBusy, 0);
        chk("t5_rst_wd", oSUfiWd, 0);
        chk("t5_rst_adrs", oSUfiWAdrs, 0);
        push(1, 32'h6100_0000, 32'h1000_0400);
        push(3, 32'h6300_0000, 32'h3000_0400);
        step();
        chk("t5_hold_wed", oSUfiWEd, 0);
        rst = 1'b1;
        step();
        chk("t5_post_rst_grant", oGrant, 4'b0010);
        chk("t5_post_rst_no_wed", oSUfiWEd, 0);
        drain("t5");

        // Downstream slave-select decode
        push(1, 32'h3000_0010, 32'h1000_0555);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            if (oSUfiWEd) done = 1'b1;
        end
        chk("t6_wed_seen", done, 1);
        chk("t6_slave_sel", oSUfiWAdrs[31:28], 4'h3);
        chk("t6_adrs", oSUfiWAdrs, 32'h3000_0010);
        step();
        chk("t6_single_pulse", oSUfiWEd, 0);
        drain("t6");

        // Randomised traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            for (int m = 0; m < N; m++) begin
                if ($urandom_range(0, 7) == 0 && beat_q[m].size() < 4) begin
                    lock_req[m] = ($urandom_range(0, 3) == 0);
                    len = (cyc % 5 == 0) ? 20 : int'($urandom_range(1, 6));
                    for (int b = 0; b < len; b++)
                        push(m, $urandom, {4'(m), 28'($urandom)});
                end
            end
        end
        drain("rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
